jtgng_romrq_arb: RTL and testbench

JTGNG_ROMRQ_ARB -- requirements
Module: jtgng_romrq_arb

---
 rtl/jtgng_romrq_arb.sv | 157 +++++++++++++++
 tb/tb_jtgng_romrq_arb.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/jtgng_romrq_arb.sv
// Four-slot SDRAM read arbiter with a one-entry cache per slot.
// Cache hits are answered locally; misses are granted round-robin, one SDRAM read at a time.
module jtgng_romrq_arb #(
  parameter int AW = 22,
  parameter int DW = 32
) (
  input  logic            rst,
  input  logic            clk,
  input  logic            downloading,
  input  logic            loop_rst,
  input  logic [3:0]      slot_req,
  input  logic [4*AW-1:0] slot_addr,
  output logic [4*DW-1:0] slot_dout,
  output logic [3:0]      slot_ok,
  output logic            sdram_req,
  output logic [AW-1:0]   sdram_addr,
  input  logic            sdram_ack,
  input  logic            data_rdy,
  input  logic [DW-1:0]   data_read,
  output logic            refresh_en
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_ACK  = 2'd1,
    WAIT_DATA = 2'd2
  } state_t;

  state_t        state;
  state_t        next_state;
  logic [AW-1:0] cache_addr [4];
  logic [3:0]    cache_valid;
  logic [3:0]    hit;
  logic [3:0]    pending;
  logic [1:0]    rr_ptr;
  logic [1:0]    gnt;
  logic [1:0]    sel;
  logic [1:0]    cand;
  logic          sel_vld;
  logic [AW-1:0] sel_addr;
  logic          abort;
  logic          issue;
  logic          ack_take;
  logic          fill;

  // hit and pending detection, independent of the FSM
  always_comb begin
    hit = 4'b0000;
    for (int n = 0; n < 4; n++) begin
      hit[n] = slot_req[n] && cache_valid[n] && (slot_addr[n*AW +: AW] == cache_addr[n]);
    end
    pending = slot_req & ~hit;
  end

  // round-robin pick: scan from rr_ptr + 3 down to rr_ptr so the nearest pending slot wins
  always_comb begin
    sel      = rr_ptr;
    sel_vld  = 1'b0;
    cand     = rr_ptr;
    sel_addr = '0;
    for (int i = 3; i >= 0; i--) begin
      cand    = rr_ptr + 2'(i);
      sel     = pending[cand] ? cand : sel;
      sel_vld = sel_vld | pending[cand];
    end
    for (int n = 0; n < 4; n++) begin
      sel_addr = (sel == 2'(n)) ? slot_addr[n*AW +: AW] : sel_addr;
    end
  end

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // next-state logic; an abort always returns to IDLE
  always_comb begin
    abort = downloading | loop_rst;
    case (state)
      IDLE:      next_state = (sel_vld && !downloading) ? WAIT_ACK : IDLE;
      WAIT_ACK:  next_state = sdram_ack ? WAIT_DATA : WAIT_ACK;
      WAIT_DATA: next_state = data_rdy ? IDLE : WAIT_DATA;
      default:   next_state = IDLE;
    endcase
    if (abort) begin
      next_state = IDLE;
    end else begin
      next_state = next_state;
    end
  end

  // per-state actions, gated by abort so an abort always wins over ack/data
  always_comb begin
    issue    = 1'b0;
    ack_take = 1'b0;
    fill     = 1'b0;
    case (state)
      IDLE:      issue    = sel_vld && !abort;
      WAIT_ACK:  ack_take = sdram_ack && !abort;
      WAIT_DATA: fill     = data_rdy && !abort;
      default:   issue    = 1'b0;
    endcase
  end

  // SDRAM request side, round-robin pointer, refresh permission and hit flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sdram_req  <= 1'b0;
      sdram_addr <= '0;
      gnt        <= 2'd0;
      rr_ptr     <= 2'd0;
      refresh_en <= 1'b0;
      slot_ok    <= 4'b0000;
    end else begin
      if (abort) begin
        sdram_req <= 1'b0;
      end else if (issue) begin
        sdram_req  <= 1'b1;
        sdram_addr <= sel_addr;
        gnt        <= sel;
      end else if (ack_take) begin
        sdram_req <= 1'b0;
      end
      if (fill) begin
        rr_ptr <= gnt + 2'd1;
      end
      refresh_en <= (state == IDLE) && (pending == 4'b0000) && !downloading;
      slot_ok    <= abort ? 4'b0000 : hit;
    end
  end

  // cache fill on data return; aborts invalidate every entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cache_valid <= 4'b0000;
      slot_dout   <= '0;
      for (int n = 0; n < 4; n++) begin
        cache_addr[n] <= '0;
      end
    end else if (abort) begin
      cache_valid <= 4'b0000;
    end else if (fill) begin
      for (int n = 0; n < 4; n++) begin
        if (gnt == 2'(n)) begin
          cache_addr[n]          <= sdram_addr;
          cache_valid[n]         <= 1'b1;
          slot_dout[n*DW +: DW]  <= data_read;
        end
      end
    end
  end

endmodule

// File: tb/tb_jtgng_romrq_arb.sv
// Directed self-checking bench for jtgng_romrq_arb: miss, hit, round-robin,
// abort, download hold-off and asynchronous reset.
module tb_jtgng_romrq_arb;
  localparam int AW = 22;
  localparam int DW = 32;

  logic            rst;
  logic            clk;
  logic            downloading;
  logic            loop_rst;
  logic [3:0]      slot_req;
  logic [4*AW-1:0] slot_addr;
  logic [4*DW-1:0] slot_dout;
  logic [3:0]      slot_ok;
  logic            sdram_req;
  logic [AW-1:0]   sdram_addr;
  logic            sdram_ack;
  logic            data_rdy;
  logic [DW-1:0]   data_read;
  logic            refresh_en;

  int checks = 0;
  int errors = 0;

  jtgng_romrq_arb #(.AW(AW), .DW(DW)) dut (
    .rst(rst), .clk(clk), .downloading(downloading), .loop_rst(loop_rst),
    .slot_req(slot_req), .slot_addr(slot_addr), .slot_dout(slot_dout),
    .slot_ok(slot_ok), .sdram_req(sdram_req), .sdram_addr(sdram_addr),
    .sdram_ack(sdram_ack), .data_rdy(data_rdy), .data_read(data_read),
    .refresh_en(refresh_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input logic [127:0] obs, input logic [127:0] expv, input string tag);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [DW-1:0] dout(input int n);
    return slot_dout[n*DW +: DW];
  endfunction

  task automatic set_slot(input int n, input logic req, input logic [AW-1:0] a);
    slot_req[n] = req;
    slot_addr[n*AW +: AW] = a;
  endtask

  // wait (bounded) for a request, check its address, then ack and return data
  task automatic serve(input logic [AW-1:0] exp_addr, input logic [DW-1:0] d, input string tag);
    int n;
    n = 0;
    while (sdram_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk(128'(sdram_req), 128'(1'b1), {tag, "_req"});
    chk(128'(sdram_addr), 128'(exp_addr), {tag, "_addr"});
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
    tick();
    data_rdy  = 1'b1;
    data_read = d;
    tick();
    data_rdy  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; downloading = 1'b0; loop_rst = 1'b0; slot_req = 4'b0000;
    slot_addr = '0; sdram_ack = 1'b0; data_rdy = 1'b0; data_read = '0;
    tick(); tick();
    chk(128'(sdram_req), 128'(1'b0), "rst_req");
    chk(128'(sdram_addr), 128'(22'h0), "rst_addr");
    chk(128'(slot_ok), 128'(4'h0), "rst_ok");
    chk(128'(refresh_en), 128'(1'b0), "rst_refresh");
    chk(slot_dout, 128'h0, "rst_dout");
    rst = 1'b0;
    tick();
    chk(128'(refresh_en), 128'(1'b1), "idle_refresh");

    // single miss: ack 3 clocks after request, data 5 clocks after ack
    set_slot(2, 1'b1, 22'h01234);
    tick();
    chk(128'(sdram_req), 128'(1'b1), "miss_req1");
    chk(128'(sdram_addr), 128'(22'h01234), "miss_addr");
    chk(128'(refresh_en), 128'(1'b0), "miss_refresh");
    tick();
    chk(128'(sdram_req), 128'(1'b1), "miss_req2");
    tick();
    chk(128'(sdram_req), 128'(1'b1), "miss_req3");
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
    chk(128'(sdram_req), 128'(1'b0), "miss_req_drop");
    tick(); tick(); tick(); tick();
    chk(128'(sdram_addr), 128'(22'h01234), "miss_addr_hold");
    data_rdy = 1'b1; data_read = 32'hDEADBEEF;
    tick();
    data_rdy = 1'b0; data_read = 32'h0;
    chk(128'(dout(2)), 128'(32'hDEADBEEF), "miss_dout");
    chk(128'(slot_ok), 128'(4'h0), "miss_ok_early");
    tick();
    chk(128'(slot_ok), 128'(4'h4), "miss_ok");
    chk(128'(sdram_req), 128'(1'b0), "miss_no_req");

    // hit: ok clears after req falls, returns one clock after req rises
    slot_req[2] = 1'b0;
    tick();
    chk(128'(slot_ok), 128'(4'h0), "hit_ok_clear");
    data_rdy = 1'b1; data_read = 32'h0BADF00D;
    slot_req[2] = 1'b1;
    tick();
    data_rdy = 1'b0;
    chk(128'(slot_ok), 128'(4'h4), "hit_ok");
    chk(128'(sdram_req), 128'(1'b0), "hit_no_req");
    chk(128'(dout(2)), 128'(32'hDEADBEEF), "stray_rdy_ignored");
    slot_req[2] = 1'b0;
    tick();

    // round-robin from reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_slot(0, 1'b1, 22'h00100);
    set_slot(1, 1'b1, 22'h00200);
    set_slot(2, 1'b1, 22'h00300);
    set_slot(3, 1'b1, 22'h00400);
    serve(22'h00100, 32'hA0A0A0A0, "rr0");
    chk(128'(dout(0)), 128'(32'hA0A0A0A0), "rr0_dout");
    set_slot(0, 1'b1, 22'h00500);
    serve(22'h00200, 32'hA1A1A1A1, "rr1");
    set_slot(1, 1'b1, 22'h00600);
    serve(22'h00300, 32'hA2A2A2A2, "rr2");
    set_slot(2, 1'b1, 22'h00700);
    serve(22'h00400, 32'hA3A3A3A3, "rr3");
    serve(22'h00500, 32'hB0B0B0B0, "rr0b");
    serve(22'h00600, 32'hB1B1B1B1, "rr1b");
    serve(22'h00700, 32'hB2B2B2B2, "rr2b");
    tick();
    chk(128'(slot_ok), 128'(4'hF), "rr_all_ok");
    chk(slot_dout, 128'hA3A3A3A3_B2B2B2B2_B1B1B1B1_B0B0B0B0, "rr_dout_all");
    slot_req = 4'b0000;
    tick();

    // abort in WAIT_DATA with coincident data_rdy
    set_slot(3, 1'b1, 22'h00400);
    tick();
    chk(128'(slot_ok), 128'(4'h8), "ab_hit3");
    set_slot(1, 1'b1, 22'h00777);
    tick();
    chk(128'(sdram_req), 128'(1'b1), "ab_req");
    chk(128'(sdram_addr), 128'(22'h00777), "ab_addr");
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
    chk(128'(slot_ok), 128'(4'h8), "ab_hit_in_wait");
    loop_rst = 1'b1; data_rdy = 1'b1; data_read = 32'h12345678;
    tick();
    loop_rst = 1'b0; data_rdy = 1'b0;
    chk(128'(sdram_req), 128'(1'b0), "ab_req_off");
    chk(128'(slot_ok), 128'(4'h0), "ab_ok_clear");
    chk(128'(dout(1)), 128'(32'hB1B1B1B1), "ab_no_fill");
    tick();
    chk(128'(sdram_req), 128'(1'b1), "ab_reissue");
    chk(128'(sdram_addr), 128'(22'h00400), "ab_reissue_addr");
    serve(22'h00400, 32'hC3C3C3C3, "ab3");
    serve(22'h00777, 32'hC1C1C1C1, "ab1");
    tick();
    chk(128'(slot_ok), 128'(4'hA), "ab_ok_after");
    chk(128'(dout(1)), 128'(32'hC1C1C1C1), "ab_dout1");
    chk(128'(refresh_en), 128'(1'b1), "ab_refresh");

    // download hold-off
    slot_req = 4'b0000;
    downloading = 1'b1;
    set_slot(0, 1'b1, 22'h00999);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk(128'(sdram_req), 128'(1'b0), "dl_req");
      chk(128'(refresh_en), 128'(1'b0), "dl_refresh");
    end
    downloading = 1'b0;
    tick();
    chk(128'(sdram_req), 128'(1'b1), "dl_issue");
    chk(128'(sdram_addr), 128'(22'h00999), "dl_addr");

    // asynchronous reset in WAIT_ACK, between edges
    #2;
    rst = 1'b1;
    #1;
    chk(128'(sdram_req), 128'(1'b0), "arst_req");
    chk(128'(sdram_addr), 128'(22'h0), "arst_addr");
    chk(128'(slot_ok), 128'(4'h0), "arst_ok");
    chk(128'(refresh_en), 128'(1'b0), "arst_refresh");
    chk(slot_dout, 128'h0, "arst_dout");
    tick();
    rst = 1'b0;
    slot_req = 4'b0000;
    tick();
    chk(128'(refresh_en), 128'(1'b1), "arst_resume");
    chk(128'(sdram_req), 128'(1'b0), "arst_idle_req");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
